// File: rtl/weight_load_ctrl_if.sv
// rtl/weight_load_ctrl_if.sv - weight beat stream and weight-buffer write bus
//
// Purpose: bundles the DMA-side beat handshake and the buffer-side write
//          strobe/address/data of weight_load_ctrl into one port.
// Signals:
//   s_data   beat data, IN_WIDTH bits          (stream source -> controller)
//   s_valid  beat valid                        (stream source -> controller)
//   s_ready  beat accepted when valid & ready  (controller -> stream source)
//   wr_en    one-cycle buffer write strobe     (controller -> buffer)
//   wr_addr  buffer word address               (controller -> buffer)
//   wr_data  packed buffer word, IN_WIDTH*PACK (controller -> buffer)
// Modports:
//   master   environment side: drives the stream, observes the write bus
//   slave    controller side: consumes the stream, drives the write bus
interface weight_load_ctrl_if #(
  parameter int IN_WIDTH      = 32,
  parameter int PACK          = 4,
  parameter int WR_ADDR_DEPTH = 10
);

  logic [IN_WIDTH-1:0]      s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     wr_en;
  logic [WR_ADDR_DEPTH-1:0] wr_addr;
  logic [IN_WIDTH*PACK-1:0] wr_data;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - packs weight beats into buffer words and writes them
//
// Purpose: after a start pulse carrying a word count, accepts IN_WIDTH-bit
//          beats, packs PACK of them per buffer word (first beat in the LSBs)
//          and writes the words to consecutive addresses from 0. Signals the
//          end of the load with a one-cycle done pulse.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     one-cycle launch request, honoured only when idle
//   word_num  words to load, sampled with start; saturates at 2^WR_ADDR_DEPTH
//   bus       weight_load_ctrl_if.slave: s_data/s_valid/s_ready stream in,
//             wr_en/wr_addr/wr_data buffer write out
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle completion pulse
module weight_load_ctrl #(
  parameter int IN_WIDTH      = 32,
  parameter int PACK          = 4,
  parameter int WR_ADDR_DEPTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WR_ADDR_DEPTH:0] word_num,
  weight_load_ctrl_if.slave      bus,
  output logic                   busy,
  output logic                   done
);

  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CNT_W  = WR_ADDR_DEPTH + 1;
  localparam int WORD_W = IN_WIDTH * PACK;
  // Lanes 0..PACK-2 are held here; the last lane goes straight into wr_data.
  localparam int HOLD_W = IN_WIDTH * (PACK - 1);

  localparam logic [CNT_W-1:0]  MAX_WORDS = {1'b1, {WR_ADDR_DEPTH{1'b0}}};
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]         count_q;
  logic [LANE_W-1:0]        lane_q;
  logic [WR_ADDR_DEPTH-1:0] word_q;
  logic [HOLD_W-1:0]        pack_q;

  logic                     wr_en_q;
  logic [WR_ADDR_DEPTH-1:0] wr_addr_q;
  logic [WORD_W-1:0]        wr_data_q;
  logic                     done_q;

  logic             s_ready_c;
  logic             busy_c;
  logic [CNT_W-1:0] eff_count;
  logic             launch;
  logic             accept;
  logic             lane_last;
  logic             word_last;
  logic             final_beat;

  // Counts beyond the buffer capacity are clamped so the address never wraps.
  assign eff_count  = (word_num > MAX_WORDS) ? MAX_WORDS : word_num;
  assign launch     = (state_q == ST_IDLE) && start;
  assign accept     = bus.s_valid && s_ready_c;
  assign lane_last  = (lane_q == LAST_LANE);
  // count_q is at least 1 whenever LOAD is entered, so the subtraction is safe.
  assign word_last  = ({1'b0, word_q} == (count_q - CNT_W'(1)));
  assign final_beat = accept && lane_last && word_last;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (eff_count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (final_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from the state register only, so s_ready never depends on s_valid.
  always_comb begin
    s_ready_c = 1'b0;
    busy_c    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        s_ready_c = 1'b1;
        busy_c    = 1'b1;
      end
      ST_DONE: begin
        busy_c = 1'b1;
      end
      default: begin
        s_ready_c = 1'b0;
        busy_c    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      // done follows the single DONE cycle, landing as busy drops.
      done_q  <= (state_q == ST_DONE);

      if (launch) begin
        count_q <= eff_count;
        lane_q  <= '0;
        word_q  <= '0;
      end else if (accept) begin
        // PACK is a power of two, so the natural wrap returns lane to 0.
        lane_q <= lane_q + LANE_W'(1);
        if (lane_last) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= word_q;
          wr_data_q <= {bus.s_data, pack_q};
          word_q    <= word_q + WR_ADDR_DEPTH'(1);
        end else begin
          for (int l = 0; l < PACK - 1; l++) begin
            if (lane_q == LANE_W'(l)) begin
              pack_q[l*IN_WIDTH +: IN_WIDTH] <= bus.s_data;
            end
          end
        end
      end
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = busy_c;
  assign done        = done_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - directed self-checking bench for weight_load_ctrl
module tb_weight_load_ctrl;

  localparam int IN_WIDTH      = 32;
  localparam int PACK          = 4;
  localparam int WR_ADDR_DEPTH = 10;
  localparam int W             = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] word_num;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  weight_load_ctrl_if #(
    .IN_WIDTH(IN_WIDTH),
    .PACK(PACK),
    .WR_ADDR_DEPTH(WR_ADDR_DEPTH)
  ) bus ();

  weight_load_ctrl #(
    .IN_WIDTH(IN_WIDTH),
    .PACK(PACK),
    .WR_ADDR_DEPTH(WR_ADDR_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word_num(word_num),
    .bus(bus.slave),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log and s_ready activity, sampled on the falling edge.
  logic [9:0]   log_addr[$];
  logic [127:0] log_data[$];
  int           log_cyc[$];
  int           ready_cycles = 0;

  always @(negedge clk) begin
    if (!rst && bus.wr_en) begin
      log_addr.push_back(bus.wr_addr);
      log_data.push_back(bus.wr_data);
      log_cyc.push_back(cyc);
    end
    if (bus.s_ready) ready_cycles <= ready_cycles + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [10:0] n);
    start    = 1'b1;
    word_num = n;
    tick();
    start = 1'b0;
  endtask

  // Streams n beats of value base+i; returns #1 after the edge that takes the last one.
  task automatic stream(input int n, input int base, input bit stalls);
    for (int i = 0; i < n; i++) begin
      if (stalls) begin
        int gaps;
        gaps = $urandom_range(2);
        bus.s_valid = 1'b0;
        repeat (gaps) tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(base + i);
      begin
        int w;
        w = 0;
        while (!bus.s_ready && w < 50) begin
          tick();
          w++;
        end
      end
      if (!bus.s_ready) begin
        check("ready_timeout", W'(0), W'(1));
        bus.s_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  function automatic int addr_seq_bad(input int b, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (b + k >= log_addr.size()) bad++;
      else if (log_addr[b+k] != 10'(k)) bad++;
    end
    return bad;
  endfunction

  int b0;
  int r0;

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    word_num    = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", W'(bus.s_ready), W'(0));
    check("rst_wr_en",   W'(bus.wr_en),   W'(0));
    check("rst_busy",    W'(busy),        W'(0));
    check("rst_done",    W'(done),        W'(0));
    check("rst_wr_addr", W'(bus.wr_addr), W'(0));
    check("rst_wr_data", W'(bus.wr_data), W'(0));
    rst = 1'b0;
    tick();

    // ---- basic load: 3 words, continuous beats 0x1..0xC
    b0 = log_addr.size();
    launch(11'd3);
    check("basic_busy_s1",  W'(busy),        W'(1));
    check("basic_ready_s1", W'(bus.s_ready), W'(1));
    stream(12, 1, 1'b0);
    check("basic_last_wr_en", W'(bus.wr_en),   W'(1));
    check("basic_last_ready", W'(bus.s_ready), W'(0));
    check("basic_last_addr",  W'(bus.wr_addr), W'(2));
    check("basic_done_t1",    W'(done),        W'(0));
    tick();
    check("basic_done_t2", W'(done),     W'(1));
    check("basic_busy_t2", W'(busy),     W'(0));
    check("basic_wr_en_t2", W'(bus.wr_en), W'(0));
    check("basic_hold_addr", W'(bus.wr_addr), W'(2));
    check("basic_hold_data", bus.wr_data, 128'h0000000C_0000000B_0000000A_00000009);
    check("basic_count", W'(log_addr.size() - b0), W'(3));
    if (log_addr.size() >= b0 + 3) begin
      check("basic_addr0", W'(log_addr[b0]),   W'(0));
      check("basic_addr1", W'(log_addr[b0+1]), W'(1));
      check("basic_addr2", W'(log_addr[b0+2]), W'(2));
      check("basic_data0", log_data[b0],   128'h00000004_00000003_00000002_00000001);
      check("basic_data1", log_data[b0+1], 128'h00000008_00000007_00000006_00000005);
      check("basic_data2", log_data[b0+2], 128'h0000000C_0000000B_0000000A_00000009);
      check("basic_gap", W'(log_cyc[b0+1] - log_cyc[b0]), W'(4));
    end
    tick();

    // ---- stalled load with start pulses during LOAD and DONE, then relaunch in done cycle
    b0 = log_addr.size();
    launch(11'd3);
    stream(5, 1, 1'b1);
    start       = 1'b1;
    word_num    = 11'd1;
    bus.s_valid = 1'b0;
    tick();
    start = 1'b0;
    check("stall_no_wr_midload", W'(log_addr.size() - b0), W'(1));
    stream(7, 6, 1'b1);
    check("stall_last_wr_en", W'(bus.wr_en), W'(1));
    start    = 1'b1;
    word_num = 11'd5;
    tick();
    start = 1'b0;
    check("stall_done", W'(done), W'(1));
    check("stall_busy", W'(busy), W'(0));
    check("stall_count", W'(log_addr.size() - b0), W'(3));
    if (log_addr.size() >= b0 + 3) begin
      check("stall_data0", log_data[b0],   128'h00000004_00000003_00000002_00000001);
      check("stall_data1", log_data[b0+1], 128'h00000008_00000007_00000006_00000005);
      check("stall_data2", log_data[b0+2], 128'h0000000C_0000000B_0000000A_00000009);
      check("stall_addr_seq", W'(addr_seq_bad(b0, 3)), W'(0));
    end
    b0 = log_addr.size();
    launch(11'd2);
    check("relaunch_busy", W'(busy), W'(1));
    stream(8, 'h31, 1'b0);
    tick();
    check("relaunch_done", W'(done), W'(1));
    check("relaunch_count", W'(log_addr.size() - b0), W'(2));
    if (log_addr.size() >= b0 + 2) begin
      check("relaunch_addr_seq", W'(addr_seq_bad(b0, 2)), W'(0));
      check("relaunch_data0", log_data[b0],   128'h00000034_00000033_00000032_00000031);
      check("relaunch_data1", log_data[b0+1], 128'h00000038_00000037_00000036_00000035);
    end
    tick();

    // ---- zero-count launch
    b0 = log_addr.size();
    r0 = ready_cycles;
    launch(11'd0);
    check("zero_busy_s1",  W'(busy),        W'(1));
    check("zero_ready_s1", W'(bus.s_ready), W'(0));
    check("zero_done_s1",  W'(done),        W'(0));
    tick();
    check("zero_done_s2", W'(done), W'(1));
    check("zero_busy_s2", W'(busy), W'(0));
    tick();
    check("zero_no_wr",    W'(log_addr.size() - b0), W'(0));
    check("zero_no_ready", W'(ready_cycles - r0),    W'(0));

    // ---- full buffer: 1024 words, no address wrap, no bubbles
    b0 = log_addr.size();
    launch(11'd1024);
    stream(4096, 1, 1'b0);
    check("full_last_wr_en", W'(bus.wr_en),   W'(1));
    check("full_last_addr",  W'(bus.wr_addr), W'(1023));
    check("full_last_data",  bus.wr_data, 128'h00001000_00000FFF_00000FFE_00000FFD);
    tick();
    check("full_done", W'(done), W'(1));
    check("full_count", W'(log_addr.size() - b0), W'(1024));
    check("full_addr_seq", W'(addr_seq_bad(b0, 1024)), W'(0));
    if (log_addr.size() >= b0 + 1024) begin
      check("full_no_bubbles", W'(log_cyc[b0+1023] - log_cyc[b0]), W'(4 * 1023));
    end
    tick();

    // ---- saturating count
    b0 = log_addr.size();
    launch(11'd2047);
    stream(4096, 1, 1'b0);
    check("sat_last_addr", W'(bus.wr_addr), W'(1023));
    check("sat_ready_off", W'(bus.s_ready), W'(0));
    tick();
    check("sat_done", W'(done), W'(1));
    check("sat_count", W'(log_addr.size() - b0), W'(1024));
    tick();

    // ---- reset mid-load, then a clean 2-word load
    launch(11'd3);
    stream(6, 1, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_s_ready", W'(bus.s_ready), W'(0));
    check("mid_rst_busy",    W'(busy),        W'(0));
    check("mid_rst_wr_en",   W'(bus.wr_en),   W'(0));
    check("mid_rst_done",    W'(done),        W'(0));
    check("mid_rst_wr_addr", W'(bus.wr_addr), W'(0));
    check("mid_rst_wr_data", W'(bus.wr_data), W'(0));
    b0 = log_addr.size();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", W'(busy), W'(0));
    launch(11'd2);
    stream(8, 'h21, 1'b0);
    tick();
    check("post_rst_done", W'(done), W'(1));
    check("post_rst_count", W'(log_addr.size() - b0), W'(2));
    if (log_addr.size() >= b0 + 2) begin
      check("post_rst_addr_seq", W'(addr_seq_bad(b0, 2)), W'(0));
      check("post_rst_data0", log_data[b0],   128'h00000024_00000023_00000022_00000021);
      check("post_rst_data1", log_data[b0+1], 128'h00000028_00000027_00000026_00000025);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
